// File: rtl/mspe_stream_pkg.sv
// Shared stream definitions for the mspe beat interface.
// The packer, the mspe core and their benches all import this package.
package mspe_stream_pkg;

   localparam int ST_DATA_W  = 512;
   localparam int ST_WORD_W  = 32;
   localparam int ST_LANES   = ST_DATA_W / ST_WORD_W;
   localparam int ST_EMPTY_W = $clog2(ST_DATA_W / 8);

   typedef struct packed {
      logic [ST_DATA_W-1:0]  data;
      logic                  sop;
      logic                  eop;
      logic [ST_EMPTY_W-1:0] empty;
   } st_beat_t;

endpackage

// File: rtl/mspe_st_packer.sv
// Packs 32-bit words into 512-bit stream beats with sop/eop/empty.
// One pack register feeds one output register, giving two beats of buffering.
module mspe_st_packer
   import mspe_stream_pkg::*;
#(
   parameter int DATA_W = ST_DATA_W,
   parameter int WORD_W = ST_WORD_W,
   localparam int LANES   = DATA_W / WORD_W,
   localparam int EMPTY_W = $clog2(DATA_W / 8)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WORD_W-1:0]  in_data,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   output logic [DATA_W-1:0]  src_data,
   output logic               src_valid,
   output logic               src_sop,
   output logic               src_eop,
   output logic [EMPTY_W-1:0] src_empty,
   input  logic               src_ready,
   output logic [31:0]        pkt_count,
   output logic               busy
);

   localparam int LANE_W = $clog2(LANES);
   localparam logic [LANE_W-1:0]  LAST_LANE  = LANE_W'(LANES - 1);
   localparam logic [EMPTY_W-1:0] WORD_BYTES = EMPTY_W'(WORD_W / 8);

   logic [LANES-1:0][WORD_W-1:0] pack;
   logic [LANE_W-1:0]            lane;
   logic                         pack_full;
   logic                         pack_last;
   logic                         sop_armed;

   st_beat_t                     out_beat;
   logic                         out_valid;

   logic                         out_free;
   logic                         xfer;
   logic                         accept;
   logic [LANE_W-1:0]            wr_lane;
   logic                         completes;
   logic [EMPTY_W-1:0]           beat_empty;

   always_comb begin
      out_free   = !out_valid || src_ready;
      in_ready   = !pack_full || out_free;
      xfer       = pack_full && out_free;
      accept     = in_valid && in_ready;
      // A transfer clears the pack this cycle, so a word accepted alongside it lands in lane 0.
      wr_lane    = xfer ? '0 : lane;
      completes  = (wr_lane == LAST_LANE) || in_last;
      beat_empty = '0;
      if (pack_last) begin
         beat_empty = EMPTY_W'(LAST_LANE - lane) * WORD_BYTES;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_beat  <= '0;
         out_valid <= 1'b0;
         sop_armed <= 1'b1;
         pkt_count <= '0;
      end else begin
         if (xfer) begin
            out_beat.data  <= pack;
            out_beat.sop   <= sop_armed;
            out_beat.eop   <= pack_last;
            out_beat.empty <= beat_empty;
            out_valid      <= 1'b1;
            sop_armed      <= pack_last;
         end else if (out_valid && src_ready) begin
            out_valid <= 1'b0;
         end
         if (out_valid && src_ready && out_beat.eop) begin
            pkt_count <= pkt_count + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pack      <= '0;
         lane      <= '0;
         pack_full <= 1'b0;
         pack_last <= 1'b0;
      end else begin
         if (xfer) begin
            pack      <= '0;
            lane      <= '0;
            pack_full <= 1'b0;
         end
         if (accept) begin
            pack[wr_lane] <= in_data;
            if (completes) begin
               pack_full <= 1'b1;
               pack_last <= in_last;
               lane      <= wr_lane;
            end else begin
               lane <= wr_lane + 1'b1;
            end
         end
      end
   end

   assign src_data  = out_beat.data;
   assign src_valid = out_valid;
   assign src_sop   = out_beat.sop;
   assign src_eop   = out_beat.eop;
   assign src_empty = out_beat.empty;
   assign busy      = (lane != '0) || pack_full || out_valid;

endmodule

// File: tb/tb_mspe_st_packer.sv
// Bench for mspe_st_packer: directed packet table, corner sequences and a
// randomized run checked against a queue-based beat model.
module tb_mspe_st_packer;
   import mspe_stream_pkg::*;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [31:0]   in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          in_ready;
   logic [511:0]  src_data;
   logic          src_valid;
   logic          src_sop;
   logic          src_eop;
   logic [5:0]    src_empty;
   logic          src_ready = 1'b1;
   logic [31:0]   pkt_count;
   logic          busy;

   mspe_st_packer dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .src_data  (src_data),
      .src_valid (src_valid),
      .src_sop   (src_sop),
      .src_eop   (src_eop),
      .src_empty (src_empty),
      .src_ready (src_ready),
      .pkt_count (pkt_count),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: words are grouped 16 at a time per packet; a short final
   // group is zero-filled and its empty count is the unused bytes.
   logic [31:0] cur_w[$];
   st_beat_t    exp_q[$];
   int          pkt_words = 0;
   int          model_pkts = 0;

   task automatic model_accept(input logic [31:0] d, input logic l);
      st_beat_t b;
      cur_w.push_back(d);
      if (cur_w.size() == 16 || l) begin
         b.data = '0;
         for (int i = 0; i < cur_w.size(); i++) b.data[i*32 +: 32] = cur_w[i];
         b.sop   = (pkt_words == 0);
         b.eop   = l;
         b.empty = l ? 6'((16 - cur_w.size()) * 4) : 6'd0;
         exp_q.push_back(b);
         pkt_words += cur_w.size();
         if (l) begin
            pkt_words = 0;
            model_pkts++;
         end
         cur_w.delete();
      end
   endtask

   int       acc_total = 0;
   int       beats_cur = 0;
   int       last_beats = 0;
   int       last_empty = 0;
   int       ir_drop = 0;
   logic     t6_mode = 1'b0;
   logic     rand_ready = 1'b0;
   logic     held = 1'b0;
   st_beat_t prev_b;
   st_beat_t eb;

   always @(negedge clk) begin
      if (reset) begin
         cur_w.delete();
         exp_q.delete();
         pkt_words  = 0;
         model_pkts = 0;
         held       = 1'b0;
         beats_cur  = 0;
      end else begin
         if (t6_mode && !in_ready) ir_drop++;
         if (held && src_valid) begin
            chk("hold_data", src_data, prev_b.data);
            chk("hold_ctrl", {src_sop, src_eop, src_empty}, {prev_b.sop, prev_b.eop, prev_b.empty});
         end
         if (src_valid && src_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL beat_unexpected: got a beat, expected none pending");
            end else begin
               eb = exp_q.pop_front();
               chk("beat_data", src_data, eb.data);
               chk("beat_sop", src_sop, eb.sop);
               chk("beat_eop", src_eop, eb.eop);
               chk("beat_empty", src_empty, eb.empty);
            end
            beats_cur++;
            if (src_eop) begin
               last_beats = beats_cur;
               last_empty = int'(src_empty);
               beats_cur  = 0;
            end
         end
         if (in_valid && in_ready) begin
            acc_total++;
            model_accept(in_data, in_last);
         end
         held   = src_valid && !src_ready;
         prev_b = '{data: src_data, sop: src_sop, eop: src_eop, empty: src_empty};
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) src_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Called and returns just after a rising edge.
   task automatic send_word(input logic [31:0] d, input logic l);
      int t = 0;
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            return;
         end
         t++;
         if (t >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready low for %0d cycles, expected acceptance", t);
            @(posedge clk);
            #1;
            return;
         end
      end
   endtask

   task automatic send_pkt(input int len, input int tag, input int gap_max);
      for (int i = 0; i < len; i++) begin
         send_word(32'((tag << 16) | i), (i == len - 1));
         if (gap_max > 0 && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            in_last  = 1'($urandom);
            repeat ($urandom_range(1, gap_max)) begin
               @(posedge clk);
               #1;
            end
         end
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      while (t < 500) begin
         @(negedge clk);
         if (!busy) break;
         t++;
      end
      if (t >= 500) begin
         n_cmp++;
         n_bad++;
         $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", t);
      end
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int len;
      int beats;
      int empty;
   } vec_t;
   vec_t vecs[8];
   int   base_pk;
   int   base_acc;

   initial begin
      vecs[0] = '{16, 1, 0};
      vecs[1] = '{3,  1, 52};
      vecs[2] = '{20, 2, 48};
      vecs[3] = '{1,  1, 60};
      vecs[4] = '{17, 2, 60};
      vecs[5] = '{32, 2, 0};
      vecs[6] = '{31, 2, 4};
      vecs[7] = '{48, 3, 0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_src_valid", src_valid, 1'b0);
      chk("rst_sop_eop", {src_sop, src_eop}, 2'b00);
      chk("rst_empty", src_empty, 6'd0);
      chk("rst_data", src_data, 512'd0);
      chk("rst_pkt_count", pkt_count, 32'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int v = 0; v < 8; v++) begin
         base_pk = int'(pkt_count);
         send_pkt(vecs[v].len, v, 0);
         in_valid = 1'b0;
         wait_idle();
         chk("vec_beats", 32'(last_beats), 32'(vecs[v].beats));
         chk("vec_empty", 32'(last_empty), 32'(vecs[v].empty));
         chk("vec_pkt_inc", 32'(int'(pkt_count) - base_pk), 32'd1);
      end
      chk("vec_pkt_total", pkt_count, 32'd8);

      // Latency: completing word accepted at edge N shows on src_valid after N+1.
      send_word(32'h1234_5678, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_n", src_valid, 1'b0);
      @(negedge clk);
      chk("lat_n1", src_valid, 1'b1);
      wait_idle();

      // Backpressure capacity: two beats, then stall.
      src_ready = 1'b0;
      base_acc  = acc_total;
      base_pk   = int'(pkt_count);
      fork
         send_pkt(40, 16'h40, 0);
         begin
            repeat (80) @(negedge clk);
            chk("bp_accepted", 32'(acc_total - base_acc), 32'd32);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_src_valid", src_valid, 1'b1);
            @(posedge clk);
            #1;
            src_ready = 1'b1;
         end
      join
      in_valid = 1'b0;
      wait_idle();
      chk("bp_accepted_all", 32'(acc_total - base_acc), 32'd40);
      chk("bp_pkt_inc", 32'(int'(pkt_count) - base_pk), 32'd1);
      chk("bp_last_empty", 32'(last_empty), 32'd32);

      // Reset mid-packet discards the partial beat.
      for (int i = 0; i < 5; i++) send_word(32'hDEAD_0000 | 32'(i), 1'b0);
      in_valid = 1'b0;
      reset    = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("mid_rst_valid", src_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_pkt", pkt_count, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      send_word(32'hCAFE_F00D, 1'b1);
      in_valid = 1'b0;
      wait_idle();
      chk("post_rst_beats", 32'(last_beats), 32'd1);
      chk("post_rst_pkt", pkt_count, 32'd1);

      // Back-to-back single-word packets at full rate.
      base_pk = int'(pkt_count);
      ir_drop = 0;
      t6_mode = 1'b1;
      for (int k = 0; k < 10; k++) send_word(32'h0600_0000 | 32'(k), 1'b1);
      in_valid = 1'b0;
      t6_mode  = 1'b0;
      wait_idle();
      chk("b2b_in_ready_drops", 32'(ir_drop), 32'd0);
      chk("b2b_pkt_inc", 32'(int'(pkt_count) - base_pk), 32'd10);
      chk("b2b_last_empty", 32'(last_empty), 32'd60);

      // Randomized lengths, idle gaps and backpressure.
      rand_ready = 1'b1;
      for (int p = 0; p < 60; p++) begin
         send_pkt($urandom_range(1, 40), 16'h100 + p, 2);
      end
      in_valid   = 1'b0;
      rand_ready = 1'b0;
      @(posedge clk);
      #2;
      src_ready = 1'b1;
      wait_idle();
      chk("rand_exp_drained", 32'(exp_q.size()), 32'd0);
      chk("rand_pkt_count", pkt_count, 32'(model_pkts));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
